// File: rtl/shot_controller_if.sv
// Shot handshake between the launcher controller and the trajectory calculator.
interface shot_controller_if;
    logic [4:0] x_pos;
    logic [4:0] rise;
    logic [4:0] run;
    logic       direction;
    logic       shoot;
    logic       result_valid;
    logic       hit;

    modport master (
        output x_pos, rise, run, direction, shoot,
        input  result_valid, hit
    );

    modport slave (
        input  x_pos, rise, run, direction, shoot,
        output result_valid, hit
    );
endinterface

// File: rtl/shot_controller.sv
// Launcher game controller: aims, fires shots at the calculator, scores hits,
// tracks lives and draws new targets from a free-running 10-bit LFSR.
module shot_controller #(
    parameter int MAX_LIVES = 3,
    parameter int TIMEOUT   = 63
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_btn_left,
    input  logic                  i_btn_right,
    input  logic                  i_btn_fire,
    input  logic [4:0]            i_rise_sel,
    input  logic [4:0]            i_run_sel,
    input  logic                  i_dir_sel,
    shot_controller_if.master     calc,
    output logic [4:0]            o_target_x,
    output logic [4:0]            o_target_y,
    output logic [7:0]            o_score,
    output logic [2:0]            o_lives,
    output logic                  o_busy,
    output logic                  o_game_over
);

    localparam logic [2:0] LIVES_INIT   = 3'(MAX_LIVES);
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_AIM   = 3'd0,
        S_FIRE  = 3'd1,
        S_WAIT  = 3'd2,
        S_SCORE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    function automatic logic [9:0] lfsr_step(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_btn_prev;
    logic [4:0] r_x_pos;
    logic [4:0] r_rise;
    logic [4:0] r_run;
    logic       r_dir;
    logic       r_shoot;
    logic [4:0] r_target_x;
    logic [4:0] r_target_y;
    logic [7:0] r_score;
    logic [2:0] r_lives;
    logic       r_busy;
    logic       r_game_over;
    logic [9:0] r_lfsr;
    logic [5:0] r_wait_cnt;
    logic       r_shot_hit;

    logic       w_left_edge;
    logic       w_right_edge;
    logic       w_fire_edge;
    logic [4:0] w_x_next;
    logic [4:0] w_new_ty;
    logic       w_latch_shot;
    logic       w_load_target;
    logic       w_score_inc;
    logic       w_life_loss;
    logic       w_restart;

    assign w_left_edge  = i_btn_left  & ~r_btn_prev[0];
    assign w_right_edge = i_btn_right & ~r_btn_prev[1];
    assign w_fire_edge  = i_btn_fire  & ~r_btn_prev[2];
    // A zero row would put the target on the launcher line, so it is bumped to 1.
    assign w_new_ty     = (r_lfsr[9:5] == 5'd0) ? 5'd1 : r_lfsr[9:5];

    // Launcher position: moves only in AIM, saturating at both edges.
    always_comb begin
        w_x_next = r_x_pos;
        if (r_state == S_AIM && (w_left_edge ^ w_right_edge)) begin
            if (w_left_edge) begin
                if (r_x_pos != 5'd0) begin
                    w_x_next = r_x_pos - 5'd1;
                end else begin
                    w_x_next = r_x_pos;
                end
            end else begin
                if (r_x_pos != 5'd31) begin
                    w_x_next = r_x_pos + 5'd1;
                end else begin
                    w_x_next = r_x_pos;
                end
            end
        end else begin
            w_x_next = r_x_pos;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_next_state  = r_state;
        w_latch_shot  = 1'b0;
        w_load_target = 1'b0;
        w_score_inc   = 1'b0;
        w_life_loss   = 1'b0;
        w_restart     = 1'b0;
        case (r_state)
            S_AIM: begin
                if (w_fire_edge && i_rise_sel != 5'd0) begin
                    w_latch_shot = 1'b1;
                    w_next_state = S_FIRE;
                end else begin
                    w_next_state = S_AIM;
                end
            end
            S_FIRE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (calc.result_valid || r_wait_cnt == TIMEOUT_LAST) begin
                    w_next_state = S_SCORE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_SCORE: begin
                if (r_shot_hit) begin
                    w_score_inc   = 1'b1;
                    w_load_target = 1'b1;
                    w_next_state  = S_AIM;
                end else begin
                    w_life_loss = 1'b1;
                    if (r_lives <= 3'd1) begin
                        w_next_state = S_OVER;
                    end else begin
                        w_next_state = S_AIM;
                    end
                end
            end
            S_OVER: begin
                if (w_fire_edge) begin
                    w_restart     = 1'b1;
                    w_load_target = 1'b1;
                    w_next_state  = S_AIM;
                end else begin
                    w_next_state = S_OVER;
                end
            end
            default: begin
                w_next_state = S_AIM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_AIM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath registers and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btn_prev  <= 3'b000;
            r_lfsr      <= 10'h001;
            r_x_pos     <= 5'd16;
            r_rise      <= 5'd0;
            r_run       <= 5'd0;
            r_dir       <= 1'b0;
            r_shoot     <= 1'b0;
            r_target_x  <= 5'd20;
            r_target_y  <= 5'd10;
            r_score     <= 8'd0;
            r_lives     <= LIVES_INIT;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
            r_wait_cnt  <= 6'd0;
            r_shot_hit  <= 1'b0;
        end else begin
            r_btn_prev <= {i_btn_fire, i_btn_right, i_btn_left};
            r_lfsr     <= lfsr_step(r_lfsr);
            r_x_pos    <= w_x_next;
            r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 6'd1 : 6'd0;
            // Overwritten every WAIT cycle; on a timeout exit it holds 0.
            r_shot_hit <= (r_state == S_WAIT) ? (calc.result_valid & calc.hit) : r_shot_hit;
            if (w_latch_shot) begin
                r_rise <= i_rise_sel;
                r_run  <= i_run_sel;
                r_dir  <= i_dir_sel;
            end
            if (w_load_target) begin
                r_target_x <= r_lfsr[4:0];
                r_target_y <= w_new_ty;
            end
            if (w_restart) begin
                r_score <= 8'd0;
            end else if (w_score_inc && r_score != 8'hFF) begin
                r_score <= r_score + 8'd1;
            end
            if (w_restart) begin
                r_lives <= LIVES_INIT;
            end else if (w_life_loss) begin
                r_lives <= r_lives - 3'd1;
            end
            r_shoot     <= (w_next_state == S_FIRE);
            r_busy      <= (w_next_state == S_FIRE) || (w_next_state == S_WAIT) ||
                           (w_next_state == S_SCORE);
            r_game_over <= (w_next_state == S_OVER);
        end
    end

    assign calc.x_pos     = r_x_pos;
    assign calc.rise      = r_rise;
    assign calc.run       = r_run;
    assign calc.direction = r_dir;
    assign calc.shoot     = r_shoot;
    assign o_target_x     = r_target_x;
    assign o_target_y     = r_target_y;
    assign o_score        = r_score;
    assign o_lives        = r_lives;
    assign o_busy         = r_busy;
    assign o_game_over    = r_game_over;

endmodule

// File: doc/shot_controller.md
SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 Parameter MAX_LIVES, default 3, lives granted at reset and restart (1..7).
REQ-002 Parameter TIMEOUT, default 63, WAIT cycles without result_valid before a forced miss (1..63).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_left  input  1  level button; each rising edge moves the launcher left.
REQ-006 btn_right  input  1  level button; each rising edge moves the launcher right.
REQ-007 btn_fire  input  1  level button; rising edge fires, or restarts from game over.
REQ-008 rise_sel, run_sel  input  5 each  requested slope for the next shot.
REQ-009 dir_sel  input  1  requested direction, 0 left / 1 right.
REQ-010 result_valid  input  1  one-cycle completion strobe from the trajectory calculator.
REQ-011 hit  input  1  calculator hit flag, meaningful only while result_valid=1.
REQ-012 x_pos, rise, run  output  5 each  registered shot parameters to the calculator.
REQ-013 direction  output  1  registered shot direction.
REQ-014 shoot  output  1  one-cycle fire pulse to the calculator.
REQ-015 target_x, target_y  output  5 each  current target coordinates.
REQ-016 score  output  8  hit count.
REQ-017 lives  output  3  remaining lives.
REQ-018 busy  output  1  high in FIRE, WAIT, SCORE.
REQ-019 game_over  output  1  high in OVER.

Function
REQ-020 States AIM, FIRE, WAIT, SCORE, OVER; registered state.
REQ-021 Button edges: each button registered once; edge = current & ~previous; a held button yields one edge.
REQ-022 AIM: left edge decrements x_pos, saturating at 0; right edge increments, saturating at 31; both edges in one cycle leave x_pos unchanged; x_pos frozen outside AIM.
REQ-023 AIM + fire edge + rise_sel!=0: latch rise_sel/run_sel/dir_sel into rise/run/direction; go to FIRE.
REQ-024 Fire edge with rise_sel=0 is ignored; stay in AIM (zero rise never terminates the calculator).
REQ-025 FIRE: shoot=1 for exactly one cycle, then WAIT; shoot=0 in every other state.
REQ-026 x_pos, rise, run, direction stable from the FIRE cycle until SCORE exits.
REQ-027 WAIT: 6-bit counter cleared on entry, +1 per cycle; result_valid=1 captures hit into a shot_hit register and goes to SCORE.
REQ-028 WAIT: counter reaching TIMEOUT with no result_valid -> SCORE with shot_hit=0; result_valid on that same cycle wins.
REQ-029 result_valid outside WAIT is ignored.
REQ-030 SCORE (one cycle): shot_hit=1 -> score+1 saturating at 255, target loads from LFSR, next AIM.
REQ-031 SCORE, shot_hit=0: lives-1; new lives 0 -> OVER, else AIM; target unchanged.
REQ-032 OVER: score and target frozen, buttons ignored except fire edge -> score=0, lives=MAX_LIVES, target loads from LFSR, next AIM.
REQ-033 LFSR: 10-bit, shifts left every cycle in every state; new bit0 = bit9 XOR bit6; target_x=lfsr[4:0], target_y=lfsr[9:5] on load.
REQ-034 A loaded target_y of 0 is replaced by 1.

Reset
REQ-035 While rst=1, next edge: state=AIM, x_pos=16, rise=run=0, direction=0, shoot=0, target_x=20, target_y=10, score=0, lives=MAX_LIVES, busy=0, game_over=0, lfsr=10'h001, wait counter=0, button history=0.
REQ-036 Reset overrides every state, including mid-WAIT; a later result_valid from the earlier shot is ignored in AIM.

Verification
REQ-037 Reset; 3 right edges, then left+right together -> x_pos 16,17,18,19,19; 20 left edges -> x_pos saturates at 0.
REQ-038 rise_sel=3, run_sel=2, dir_sel=1, fire edge -> next cycle shoot=1 one cycle, rise=3, run=2, direction=1, busy=1; holding btn_fire gives no second shot.
REQ-039 In WAIT, result_valid=1 with hit=1 -> score 0->1, new target_y!=0, state AIM; hit=0 -> lives 3->2.
REQ-040 TIMEOUT=5, no result_valid -> SCORE exactly 5 cycles after WAIT entry, lives-1; result_valid on cycle 5 instead -> that result used.
REQ-041 MAX_LIVES=3, three misses -> game_over=1, lives=0; fire edge -> score=0, lives=3, AIM.
REQ-042 rise_sel=0 fire edge -> no shoot, AIM; rst asserted in WAIT -> all REQ-035 values next cycle.
